// File: rtl/hwpe_ctrl_vfpu_package.sv
// Shared types and default widths for the VFPU HWPE job sequencer.
// job_t is sized by the SEQ_* localparams, so they must match the top-level parameters.
package hwpe_ctrl_vfpu_package;

    localparam int unsigned SEQ_NB_OPERANDS = 2;
    localparam int unsigned SEQ_N_CORES     = 2;
    localparam int unsigned SEQ_N_CONTEXT   = 2;
    localparam int unsigned SEQ_LEN_WIDTH   = 16;
    localparam int unsigned SEQ_ADDR_WIDTH  = 32;
    localparam int unsigned SEQ_OP_WIDTH    = 4;
    localparam int unsigned SEQ_CORE_WIDTH  = (SEQ_N_CORES > 1) ? $clog2(SEQ_N_CORES) : 1;

    typedef struct packed {
        logic [SEQ_CORE_WIDTH-1:0]                      core;
        logic [SEQ_LEN_WIDTH-1:0]                       len;
        logic [SEQ_OP_WIDTH-1:0]                        op;
        logic [SEQ_NB_OPERANDS-1:0]                     mask;
        logic [SEQ_NB_OPERANDS-1:0][SEQ_ADDR_WIDTH-1:0] src_addr;
        logic [SEQ_ADDR_WIDTH-1:0]                      dst_addr;
    } job_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        EVENT
    } seq_state_e;

endpackage

// File: rtl/hwpe_job_fifo.sv
// Power-of-two deep FIFO of job records with occupancy count and synchronous flush.
module hwpe_job_fifo
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  job_t                   data_i,
    input  logic                   pop_i,
    output job_t                   data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q < FULL);
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/hwpe_job_sequencer.sv
// Job-level controller for the VFPU HWPE: queues decoded jobs, starts the streamers,
// collects done pulses and raises a per-core completion event; abort flushes everything.
module hwpe_job_sequencer
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned NB_OPERANDS = SEQ_NB_OPERANDS,
    parameter int unsigned N_CORES     = SEQ_N_CORES,
    parameter int unsigned N_CONTEXT   = SEQ_N_CONTEXT,
    parameter int unsigned LEN_WIDTH   = SEQ_LEN_WIDTH,
    parameter int unsigned ADDR_WIDTH  = SEQ_ADDR_WIDTH,
    parameter int unsigned OP_WIDTH    = SEQ_OP_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              abort_i,
    input  logic                              job_valid_i,
    output logic                              job_ready_o,
    input  logic [$clog2(N_CORES)-1:0]        job_core_i,
    input  logic [LEN_WIDTH-1:0]              job_len_i,
    input  logic [OP_WIDTH-1:0]               job_op_i,
    input  logic [NB_OPERANDS-1:0]            job_mask_i,
    input  logic [NB_OPERANDS*ADDR_WIDTH-1:0] job_src_addr_i,
    input  logic [ADDR_WIDTH-1:0]             job_dst_addr_i,
    output logic [NB_OPERANDS-1:0]            src_start_o,
    output logic [NB_OPERANDS*ADDR_WIDTH-1:0] src_addr_o,
    output logic                              sink_start_o,
    output logic [ADDR_WIDTH-1:0]             sink_addr_o,
    output logic [LEN_WIDTH-1:0]              len_o,
    output logic [OP_WIDTH-1:0]               vfpu_op_o,
    input  logic [NB_OPERANDS-1:0]            src_done_i,
    input  logic                              sink_done_i,
    output logic                              clear_o,
    output logic [N_CORES-1:0]                evt_o,
    output logic                              busy_o,
    output logic [$clog2(N_CONTEXT):0]        queue_cnt_o
);

    localparam int unsigned CNT_W = $clog2(N_CONTEXT) + 1;
    localparam logic [CNT_W-1:0] CTX_FULL = N_CONTEXT[CNT_W-1:0];

    seq_state_e                        state_q, state_d;
    job_t                              job_in;
    job_t                              head;
    logic                              push;
    logic                              pop;
    logic                              latch;
    logic [CNT_W-1:0]                  count;
    logic [NB_OPERANDS-1:0]            flags_src_q, flags_src_d;
    logic                              flags_sink_q, flags_sink_d;
    logic                              src_all;
    logic                              sink_all;
    logic [$clog2(N_CORES)-1:0]        core_q;
    logic [LEN_WIDTH-1:0]              len_q;
    logic [OP_WIDTH-1:0]               op_q;
    logic [NB_OPERANDS-1:0]            mask_q;
    logic [NB_OPERANDS*ADDR_WIDTH-1:0] src_addr_q;
    logic [ADDR_WIDTH-1:0]             dst_addr_q;
    logic                              clear_q;

    always_comb begin
        job_in.core     = job_core_i;
        job_in.len      = job_len_i;
        job_in.op       = job_op_i;
        job_in.mask     = job_mask_i;
        job_in.src_addr = job_src_addr_i;
        job_in.dst_addr = job_dst_addr_i;
    end

    // Ready looks only at the registered count, so a full queue refuses a push even while popping.
    assign job_ready_o = (count < CTX_FULL) && !abort_i;
    assign push        = job_valid_i && job_ready_o;

    hwpe_job_fifo #(
        .DEPTH (N_CONTEXT)
    ) i_job_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (abort_i),
        .push_i  (push),
        .data_i  (job_in),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    assign src_all  = &(flags_src_q | src_done_i | ~mask_q);
    assign sink_all = flags_sink_q | sink_done_i;

    always_comb begin
        state_d      = state_q;
        flags_src_d  = flags_src_q;
        flags_sink_d = flags_sink_q;
        latch        = 1'b0;
        pop          = 1'b0;
        src_start_o  = '0;
        sink_start_o = 1'b0;
        evt_o        = '0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    latch   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                flags_src_d  = '0;
                flags_sink_d = 1'b0;
                if ((len_q == '0) || (mask_q == '0)) begin
                    state_d = EVENT;
                end else begin
                    src_start_o  = mask_q;
                    sink_start_o = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                flags_src_d  = flags_src_q | (src_done_i & mask_q);
                flags_sink_d = sink_all;
                if (src_all && sink_all) begin
                    state_d = EVENT;
                end
            end
            EVENT: begin
                pop = 1'b1;
                if (32'(core_q) < N_CORES) begin
                    evt_o[core_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides every pulse and sends the FSM home; the FIFO flushes in parallel.
        if (abort_i) begin
            state_d      = IDLE;
            latch        = 1'b0;
            pop          = 1'b0;
            src_start_o  = '0;
            sink_start_o = 1'b0;
            evt_o        = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            flags_src_q  <= '0;
            flags_sink_q <= 1'b0;
            core_q       <= '0;
            len_q        <= '0;
            op_q         <= '0;
            mask_q       <= '0;
            src_addr_q   <= '0;
            dst_addr_q   <= '0;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_src_q  <= flags_src_d;
            flags_sink_q <= flags_sink_d;
            clear_q      <= abort_i;
            if (latch) begin
                core_q     <= head.core;
                len_q      <= head.len;
                op_q       <= head.op;
                mask_q     <= head.mask;
                src_addr_q <= head.src_addr;
                dst_addr_q <= head.dst_addr;
            end
        end
    end

    assign src_addr_o  = src_addr_q;
    assign sink_addr_o = dst_addr_q;
    assign len_o       = len_q;
    assign vfpu_op_o   = op_q;
    assign clear_o     = clear_q;
    assign busy_o      = (state_q != IDLE) || (count != '0);
    assign queue_cnt_o = count;

endmodule

// File: tb/tb_hwpe_job_sequencer.sv
// Self-checking bench for hwpe_job_sequencer: directed scenarios plus randomized jobs
// checked against a cycle-schedule model of the job life cycle.
module tb_hwpe_job_sequencer;

    localparam int NB   = 2;
    localparam int NC   = 2;
    localparam int LW   = 16;
    localparam int AW   = 32;
    localparam int OW   = 4;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           abort_i = 1'b0;
    logic           job_valid_i = 1'b0;
    logic           job_ready_o;
    logic [0:0]     job_core_i = '0;
    logic [LW-1:0]  job_len_i = '0;
    logic [OW-1:0]  job_op_i = '0;
    logic [NB-1:0]  job_mask_i = '0;
    logic [NB*AW-1:0] job_src_addr_i = '0;
    logic [AW-1:0]  job_dst_addr_i = '0;
    logic [NB-1:0]  src_start_o;
    logic [NB*AW-1:0] src_addr_o;
    logic           sink_start_o;
    logic [AW-1:0]  sink_addr_o;
    logic [LW-1:0]  len_o;
    logic [OW-1:0]  vfpu_op_o;
    logic [NB-1:0]  src_done_i = '0;
    logic           sink_done_i = 1'b0;
    logic           clear_o;
    logic [NC-1:0]  evt_o;
    logic           busy_o;
    logic [1:0]     queue_cnt_o;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [0:0]       core;
        logic [LW-1:0]    len;
        logic [OW-1:0]    op;
        logic [NB-1:0]    mask;
        logic [NB*AW-1:0] src;
        logic [AW-1:0]    dst;
    } job_s;

    hwpe_job_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .abort_i        (abort_i),
        .job_valid_i    (job_valid_i),
        .job_ready_o    (job_ready_o),
        .job_core_i     (job_core_i),
        .job_len_i      (job_len_i),
        .job_op_i       (job_op_i),
        .job_mask_i     (job_mask_i),
        .job_src_addr_i (job_src_addr_i),
        .job_dst_addr_i (job_dst_addr_i),
        .src_start_o    (src_start_o),
        .src_addr_o     (src_addr_o),
        .sink_start_o   (sink_start_o),
        .sink_addr_o    (sink_addr_o),
        .len_o          (len_o),
        .vfpu_op_o      (vfpu_op_o),
        .src_done_i     (src_done_i),
        .sink_done_i    (sink_done_i),
        .clear_o        (clear_o),
        .evt_o          (evt_o),
        .busy_o         (busy_o),
        .queue_cnt_o    (queue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle; pulse-type inputs are dropped right after the edge.
    task automatic step();
        @(posedge clk_i);
        #2;
        job_valid_i = 1'b0;
        src_done_i  = '0;
        sink_done_i = 1'b0;
        abort_i     = 1'b0;
    endtask

    function automatic job_s mkJob(input int core, input int len, input int op, input int mask);
        job_s j;
        j.core = 1'(core);
        j.len  = LW'(len);
        j.op   = OW'(op);
        j.mask = NB'(mask);
        j.src  = {$urandom(), $urandom()};
        j.dst  = $urandom();
        return j;
    endfunction

    task automatic driveJob(input job_s j);
        job_core_i     = j.core;
        job_len_i      = j.len;
        job_op_i       = j.op;
        job_mask_i     = j.mask;
        job_src_addr_i = j.src;
        job_dst_addr_i = j.dst;
        job_valid_i    = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        nChecks++; if (job_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", job_ready_o); else nPass++;
        nChecks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_o); else nPass++;
        nChecks++; if (queue_cnt_o !== 2'd0) $display("[TB] FAIL reset_cnt: got %0d want 0", queue_cnt_o); else nPass++;
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL reset_evt: got %b want 00", evt_o); else nPass++;
        nChecks++; if (clear_o !== 1'b0) $display("[TB] FAIL reset_clear: got %b want 0", clear_o); else nPass++;
        nChecks++; if ({src_start_o, sink_start_o} !== 3'b000) $display("[TB] FAIL reset_starts: got %b want 000", {src_start_o, sink_start_o}); else nPass++;
        nChecks++; if ({len_o, vfpu_op_o} !== '0) $display("[TB] FAIL reset_len_op: got %h want 0", {len_o, vfpu_op_o}); else nPass++;
        nChecks++; if ({src_addr_o, sink_addr_o} !== '0) $display("[TB] FAIL reset_addr: got %h want 0", {src_addr_o, sink_addr_o}); else nPass++;
    endtask

    task automatic test_basic();
        job_s j = mkJob(1, 8, 3, 2'b11);
        driveJob(j);
        step();
        nChecks++; if (queue_cnt_o !== 2'd1) $display("[TB] FAIL basic_cnt: got %0d want 1", queue_cnt_o); else nPass++;
        nChecks++; if (busy_o !== 1'b1) $display("[TB] FAIL basic_busy: got %b want 1", busy_o); else nPass++;
        nChecks++; if (src_start_o !== 2'b00) $display("[TB] FAIL basic_early_start: got %b want 00", src_start_o); else nPass++;
        step();
        nChecks++; if (src_start_o !== 2'b11) $display("[TB] FAIL basic_src_start: got %b want 11", src_start_o); else nPass++;
        nChecks++; if (sink_start_o !== 1'b1) $display("[TB] FAIL basic_sink_start: got %b want 1", sink_start_o); else nPass++;
        nChecks++; if (len_o !== 16'd8 || vfpu_op_o !== 4'd3) $display("[TB] FAIL basic_len_op: got %0d/%0d want 8/3", len_o, vfpu_op_o); else nPass++;
        nChecks++; if (src_addr_o !== j.src || sink_addr_o !== j.dst) $display("[TB] FAIL basic_addr: got %h/%h want %h/%h", src_addr_o, sink_addr_o, j.src, j.dst); else nPass++;
        step();
        nChecks++; if (src_start_o !== 2'b00 || sink_start_o !== 1'b0) $display("[TB] FAIL basic_start_width: got %b%b want 000", src_start_o, sink_start_o); else nPass++;
        src_done_i = 2'b01;
        step();
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL basic_evt_early1: got %b want 00", evt_o); else nPass++;
        src_done_i = 2'b10;
        step();
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL basic_evt_early2: got %b want 00", evt_o); else nPass++;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b10) $display("[TB] FAIL basic_evt: got %b want 10", evt_o); else nPass++;
        step();
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL basic_evt_once: got %b want 00", evt_o); else nPass++;
        nChecks++; if (busy_o !== 1'b0 || queue_cnt_o !== 2'd0) $display("[TB] FAIL basic_idle: got busy %b cnt %0d want 0/0", busy_o, queue_cnt_o); else nPass++;
    endtask

    task automatic test_mask();
        job_s j = mkJob(0, 5, 7, 2'b01);
        driveJob(j);
        step();
        step();
        nChecks++; if (src_start_o !== 2'b01 || sink_start_o !== 1'b1) $display("[TB] FAIL mask_start: got %b%b want 011", src_start_o, sink_start_o); else nPass++;
        step();
        src_done_i  = 2'b10;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL mask_spurious: got %b want 00", evt_o); else nPass++;
        step();
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL mask_wait: got %b want 00", evt_o); else nPass++;
        src_done_i = 2'b01;
        step();
        nChecks++; if (evt_o !== 2'b01) $display("[TB] FAIL mask_evt: got %b want 01", evt_o); else nPass++;
        step();
    endtask

    task automatic test_len_zero();
        job_s j = mkJob(0, 0, 1, 2'b11);
        driveJob(j);
        step();
        step();
        nChecks++; if ({src_start_o, sink_start_o} !== 3'b000) $display("[TB] FAIL len0_no_start: got %b want 000", {src_start_o, sink_start_o}); else nPass++;
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL len0_evt_early: got %b want 00", evt_o); else nPass++;
        step();
        nChecks++; if (evt_o !== 2'b01) $display("[TB] FAIL len0_evt: got %b want 01", evt_o); else nPass++;
        step();
        nChecks++; if (evt_o !== 2'b00 || busy_o !== 1'b0) $display("[TB] FAIL len0_idle: got evt %b busy %b want 00/0", evt_o, busy_o); else nPass++;
    endtask

    task automatic test_back_to_back();
        job_s a = mkJob(0, 4, 2, 2'b01);
        job_s b = mkJob(1, 6, 4, 2'b11);
        job_s c = mkJob(0, 3, 5, 2'b10);
        driveJob(a);
        step();
        nChecks++; if (job_ready_o !== 1'b1) $display("[TB] FAIL b2b_ready1: got %b want 1", job_ready_o); else nPass++;
        driveJob(b);
        step();
        nChecks++; if (queue_cnt_o !== 2'd2 || job_ready_o !== 1'b0) $display("[TB] FAIL b2b_full: got cnt %0d ready %b want 2/0", queue_cnt_o, job_ready_o); else nPass++;
        nChecks++; if (src_start_o !== 2'b01) $display("[TB] FAIL b2b_start_a: got %b want 01", src_start_o); else nPass++;
        driveJob(c);
        step();
        nChecks++; if (queue_cnt_o !== 2'd2 || job_ready_o !== 1'b0) $display("[TB] FAIL b2b_stall: got cnt %0d ready %b want 2/0", queue_cnt_o, job_ready_o); else nPass++;
        driveJob(c);
        src_done_i  = 2'b01;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b01) $display("[TB] FAIL b2b_evt_a: got %b want 01", evt_o); else nPass++;
        nChecks++; if (job_ready_o !== 1'b0 || queue_cnt_o !== 2'd2) $display("[TB] FAIL b2b_pop_ready: got ready %b cnt %0d want 0/2", job_ready_o, queue_cnt_o); else nPass++;
        driveJob(c);
        step();
        nChecks++; if (queue_cnt_o !== 2'd1 || job_ready_o !== 1'b1) $display("[TB] FAIL b2b_after_pop: got cnt %0d ready %b want 1/1", queue_cnt_o, job_ready_o); else nPass++;
        driveJob(c);
        step();
        nChecks++; if (queue_cnt_o !== 2'd2 || src_start_o !== 2'b11 || len_o !== 16'd6) $display("[TB] FAIL b2b_start_b: got cnt %0d start %b len %0d want 2/11/6", queue_cnt_o, src_start_o, len_o); else nPass++;
        step();
        src_done_i  = 2'b11;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b10) $display("[TB] FAIL b2b_evt_b: got %b want 10", evt_o); else nPass++;
        step();
        step();
        nChecks++; if (src_start_o !== 2'b10 || len_o !== 16'd3 || sink_addr_o !== c.dst) $display("[TB] FAIL b2b_start_c: got %b len %0d dst %h want 10/3/%h", src_start_o, len_o, sink_addr_o, c.dst); else nPass++;
        step();
        src_done_i  = 2'b10;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b01) $display("[TB] FAIL b2b_evt_c: got %b want 01", evt_o); else nPass++;
        step();
        nChecks++; if (busy_o !== 1'b0) $display("[TB] FAIL b2b_idle: got %b want 0", busy_o); else nPass++;
    endtask

    task automatic test_abort();
        job_s x = mkJob(1, 4, 6, 2'b11);
        job_s y = mkJob(0, 2, 8, 2'b01);
        job_s z = mkJob(0, 2, 9, 2'b01);
        driveJob(x);
        step();
        driveJob(y);
        step();
        step();
        abort_i     = 1'b1;
        src_done_i  = 2'b11;
        sink_done_i = 1'b1;
        driveJob(y);
        nChecks++; if (job_ready_o !== 1'b0) $display("[TB] FAIL abort_ready: got %b want 0", job_ready_o); else nPass++;
        step();
        nChecks++; if (clear_o !== 1'b1) $display("[TB] FAIL abort_clear: got %b want 1", clear_o); else nPass++;
        nChecks++; if (queue_cnt_o !== 2'd0 || busy_o !== 1'b0) $display("[TB] FAIL abort_flush: got cnt %0d busy %b want 0/0", queue_cnt_o, busy_o); else nPass++;
        nChecks++; if (evt_o !== 2'b00) $display("[TB] FAIL abort_evt0: got %b want 00", evt_o); else nPass++;
        step();
        nChecks++; if (clear_o !== 1'b0 || evt_o !== 2'b00) $display("[TB] FAIL abort_after: got clear %b evt %b want 0/00", clear_o, evt_o); else nPass++;
        driveJob(z);
        step();
        step();
        nChecks++; if (src_start_o !== 2'b01 || len_o !== 16'd2 || vfpu_op_o !== 4'd9) $display("[TB] FAIL abort_restart: got %b len %0d op %0d want 01/2/9", src_start_o, len_o, vfpu_op_o); else nPass++;
        step();
        src_done_i  = 2'b01;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b01) $display("[TB] FAIL abort_restart_evt: got %b want 01", evt_o); else nPass++;
        step();
    endtask

    task automatic test_same_cycle_and_reset();
        job_s d = mkJob(1, 3, 1, 2'b11);
        job_s e = mkJob(0, 7, 2, 2'b11);
        driveJob(d);
        step();
        step();
        step();
        src_done_i  = 2'b11;
        sink_done_i = 1'b1;
        step();
        nChecks++; if (evt_o !== 2'b10) $display("[TB] FAIL same_cycle_evt: got %b want 10", evt_o); else nPass++;
        step();
        driveJob(e);
        step();
        step();
        step();
        src_done_i = 2'b01;
        rst_i      = 1'b1;
        step();
        rst_i = 1'b0;
        nChecks++; if ({evt_o, busy_o, clear_o, src_start_o, sink_start_o} !== '0) $display("[TB] FAIL midrun_reset_ctrl: got %b want 0", {evt_o, busy_o, clear_o, src_start_o, sink_start_o}); else nPass++;
        nChecks++; if ({len_o, vfpu_op_o, src_addr_o, sink_addr_o} !== '0) $display("[TB] FAIL midrun_reset_held: got %h want 0", {len_o, vfpu_op_o, src_addr_o, sink_addr_o}); else nPass++;
        nChecks++; if (queue_cnt_o !== 2'd0 || job_ready_o !== 1'b1) $display("[TB] FAIL midrun_reset_queue: got cnt %0d ready %b want 0/1", queue_cnt_o, job_ready_o); else nPass++;
    endtask

    // Model: START two cycles after a push into an empty idle queue, or two cycles after the
    // previous EVENT; EVENT one cycle after START for empty jobs, else one cycle after the last done.
    task automatic test_random();
        job_s q[$];
        job_s j;
        int n;
        int last;
        int dly[NB];
        int dlySink;
        logic [NB-1:0] expStart;
        logic [NC-1:0] expEvt;
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 2);
            for (int k = 0; k < n; k++) begin
                j = mkJob($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100),
                          $urandom_range(0, 15), $urandom_range(0, 3));
                q.push_back(j);
                nChecks++; if (job_ready_o !== 1'b1) $display("[TB] FAIL rand_ready: got %b want 1", job_ready_o); else nPass++;
                driveJob(j);
                step();
            end
            if (n == 1) step();
            while (q.size() != 0) begin
                j = q.pop_front();
                expStart = (j.len == '0 || j.mask == '0) ? '0 : j.mask;
                expEvt   = NC'(1) << j.core;
                nChecks++; if (src_start_o !== expStart || sink_start_o !== (expStart != '0)) $display("[TB] FAIL rand_start: got %b%b want %b%b", src_start_o, sink_start_o, expStart, expStart != '0); else nPass++;
                nChecks++; if (len_o !== j.len || vfpu_op_o !== j.op) $display("[TB] FAIL rand_len_op: got %0d/%0d want %0d/%0d", len_o, vfpu_op_o, j.len, j.op); else nPass++;
                nChecks++; if (src_addr_o !== j.src || sink_addr_o !== j.dst) $display("[TB] FAIL rand_addr: got %h/%h want %h/%h", src_addr_o, sink_addr_o, j.src, j.dst); else nPass++;
                step();
                if (expStart != '0) begin
                    dlySink = $urandom_range(0, 3);
                    last    = dlySink;
                    for (int ch = 0; ch < NB; ch++) begin
                        dly[ch] = $urandom_range(0, 3);
                        if (j.mask[ch] && dly[ch] > last) last = dly[ch];
                    end
                    for (int k = 0; k <= last; k++) begin
                        nChecks++; if (evt_o !== '0) $display("[TB] FAIL rand_evt_early: got %b want 00", evt_o); else nPass++;
                        for (int ch = 0; ch < NB; ch++) begin
                            if (j.mask[ch] && dly[ch] == k) src_done_i[ch] = 1'b1;
                        end
                        if (dlySink == k) sink_done_i = 1'b1;
                        src_done_i = src_done_i | (~j.mask & NB'($urandom()));
                        step();
                    end
                end
                nChecks++; if (evt_o !== expEvt) $display("[TB] FAIL rand_evt: got %b want %b", evt_o, expEvt); else nPass++;
                step();
                nChecks++; if (evt_o !== '0) $display("[TB] FAIL rand_evt_once: got %b want 00", evt_o); else nPass++;
                if (q.size() != 0) step();
            end
            nChecks++; if (busy_o !== 1'b0) $display("[TB] FAIL rand_idle: got %b want 0", busy_o); else nPass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_len_zero();
        test_back_to_back();
        test_abort();
        test_same_cycle_and_reset();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
